// File: rtl/spi_msg_engine.sv
// rtl/spi_msg_engine.sv - buffer port-B scanner that executes pending messages as SPI mode-0 frames
module spi_msg_engine #(
  parameter int DEPTH   = 256,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        buf_en,
  output logic        buf_we,
  output logic [7:0]  buf_addr,
  output logic [31:0] buf_wdata,
  input  logic [31:0] buf_rdata,
  input  logic        buf_ack,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n,
  output logic        busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_READ  = 4'd1;
  localparam logic [3:0] S_RWAIT = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_SETUP = 4'd4;
  localparam logic [3:0] S_SHIFT = 4'd5;
  localparam logic [3:0] S_HOLD  = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_WWAIT = 4'd8;
  localparam logic [3:0] S_WGAP  = 4'd9;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [7:0] PTR_LAST = 8'(DEPTH - 1);

  logic [3:0]  state;
  logic [7:0]  ptr;
  logic [7:0]  ptr_next;
  logic [7:0]  cnt;
  logic [31:0] word;
  logic [14:0] tx;
  logic [7:0]  rx;
  logic [3:0]  bit_cnt;

  assign ptr_next = (ptr == PTR_LAST) ? 8'd0 : ptr + 8'd1;
  assign buf_addr = ptr;
  assign buf_en   = (state == S_READ) || (state == S_WRITE);
  assign buf_we   = (state == S_WRITE);
  assign cs_n     = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));
  // Every state from CS setup through the post-write gap is encoded at or above S_SETUP.
  assign busy     = (state >= S_SETUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 8'd0;
      cnt       <= 8'd0;
      word      <= 32'd0;
      tx        <= 15'd0;
      rx        <= 8'd0;
      bit_cnt   <= 4'd0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      buf_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (enable) state <= S_READ;
        S_READ: state <= S_RWAIT;
        S_RWAIT: begin
          if (buf_ack) begin
            word  <= buf_rdata;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (word[30] && !word[31]) begin
            tx    <= word[14:0];
            mosi  <= word[15];
            cnt   <= 8'd0;
            state <= S_SETUP;
          end else begin
            ptr   <= ptr_next;
            state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= 8'd0;
            bit_cnt <= 4'd0;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (!sclk) begin
              sclk <= 1'b1;
              rx   <= {rx[6:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                mosi  <= 1'b0;
                state <= S_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                mosi    <= tx[14];
                tx      <= {tx[13:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt == GAP_LAST) begin
            cnt       <= 8'd0;
            // rx holds the final 8 miso samples, i.e. the slave's data byte.
            buf_wdata <= {2'b11, word[29:8], (word[15] ? rx : word[7:0])};
            state     <= S_WRITE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WRITE: state <= S_WWAIT;
        S_WWAIT: begin
          if (buf_ack) begin
            cnt   <= 8'd0;
            state <= S_WGAP;
          end
        end
        S_WGAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 8'd0;
            ptr   <= ptr_next;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_msg_engine.sv
// tb/tb_spi_msg_engine.sv - scoreboard bench: buffer model, SPI slave model, randomized messages
module tb_spi_msg_engine;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable;
  logic        buf_en, buf_we;
  logic [7:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata = 32'd0;
  logic        buf_ack = 1'b0;
  logic        sclk, mosi, miso, cs_n, busy;

  always #5 clk = ~clk;

  spi_msg_engine #(.DEPTH(256), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .buf_en(buf_en), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata), .buf_ack(buf_ack),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] word;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem   [256];
  logic [31:0] model [256];
  logic [7:0]  slave_reg [128];
  exp_t        exp_q[$];
  logic [15:0] frame_q[$];
  logic [7:0]  scan_ptr = 8'd0;
  int          reads = 0;
  int          exp_total = 0;
  int          exp_dropped = 0;
  int          busy_rises = 0;
  int          cs_falls = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] wb_word(input logic [31:0] w);
    logic [7:0] d;
    d = w[15] ? slave_reg[w[14:8]] : w[7:0];
    return {2'b11, w[29:8], d};
  endfunction

  function automatic logic [31:0] rand_pending(input bit rd);
    logic [31:0] w;
    w = $urandom;
    w[31:30] = 2'b01;
    w[15] = rd;
    return w;
  endfunction

  task automatic load(input logic [7:0] a, input logic [31:0] w);
    mem[a] = w;
    model[a] = w;
  endtask

  // Pending entries are executed in scan order starting at the current pointer.
  task automatic build_expected();
    exp_t e;
    logic [7:0] a;
    for (int k = 0; k < 256; k++) begin
      a = scan_ptr + 8'(k);
      if (model[a][30] && !model[a][31]) begin
        e.addr = a;
        e.word = wb_word(model[a]);
        exp_q.push_back(e);
        frame_q.push_back(model[a][15:0]);
        exp_total++;
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Buffer port-B model: one access per enable pulse, ack after 0..2 extra cycles.
  logic [7:0] b_addr;
  logic       b_rd;
  int         b_lat;
  always begin
    @(negedge clk);
    if (rst_n && buf_en) begin
      b_addr = buf_addr;
      b_rd   = !buf_we;
      if (buf_we) mem[b_addr] = buf_wdata;
      b_lat = $urandom_range(0, 2);
      @(posedge clk);
      repeat (b_lat) @(posedge clk);
      #1;
      buf_ack   = 1'b1;
      buf_rdata = b_rd ? mem[b_addr] : $urandom;
      @(posedge clk);
      #1;
      buf_ack = 1'b0;
    end
  end

  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && buf_en && buf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", buf_addr, buf_wdata);
      end else begin
        e_mon = exp_q.pop_front();
        check("wb_addr", buf_addr, e_mon.addr);
        check("wb_data", buf_wdata, e_mon.word);
        check("busy_during_write", busy, 1);
        model[e_mon.addr] = e_mon.word;
      end
    end
    if (rst_n && buf_en && !buf_we) begin
      check("scan_addr", buf_addr, scan_ptr);
      scan_ptr = scan_ptr + 8'd1;
      reads++;
    end
  end

  logic prev_busy = 1'b0;
  logic prev_cs = 1'b1;
  logic had_frame = 1'b0;
  int   cs_high = 0;
  always @(negedge clk) begin
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
    if (cs_n) begin
      cs_high++;
    end else begin
      if (prev_cs) begin
        cs_falls++;
        if (had_frame) check("cs_gap", cs_high >= CS_GAP, 1);
        had_frame = 1'b1;
      end
      cs_high = 0;
    end
    prev_cs = cs_n;
  end

  int   run = 0;
  logic prev_s = 1'b0;
  logic seen_fall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || cs_n) begin
      run = 0;
      prev_s = 1'b0;
      seen_fall = 1'b0;
    end else if (sclk != prev_s) begin
      if (prev_s) check("sclk_high_cycles", run, CLK_DIV);
      else if (seen_fall) check("sclk_low_cycles", run, CLK_DIV);
      if (prev_s) seen_fall = 1'b1;
      prev_s = sclk;
      run = 1;
    end else begin
      run++;
    end
  end

  // SPI slave: first byte is junk, second byte is slave_reg[addr] from the frame header.
  logic [15:0] slave_rx = 16'd0;
  logic [6:0]  slave_addr = 7'd0;
  logic [7:0]  slave_byte;
  logic [15:0] f_exp;
  int          rise_cnt = 0;

  always @(negedge cs_n) begin
    rise_cnt = 0;
    slave_rx = 16'd0;
    miso = 1'($urandom_range(0, 1));
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      slave_rx = {slave_rx[14:0], mosi};
      rise_cnt++;
      if (rise_cnt == 8) slave_addr = slave_rx[6:0];
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && rst_n) begin
      if (rise_cnt >= 8 && rise_cnt < 16) begin
        slave_byte = slave_reg[slave_addr];
        miso = slave_byte[15 - rise_cnt];
      end else if (rise_cnt < 8) begin
        miso = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(posedge cs_n) begin
    if (rst_n) begin
      if (frame_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got %h expected none", slave_rx);
      end else begin
        f_exp = frame_q.pop_front();
        check("mosi_frame", slave_rx, f_exp);
        check("sclk_rises", rise_cnt, 16);
      end
    end
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] w;
  logic [31:0] w30;
  int          r0, f0, t;
  initial begin
    enable = 1'b0;
    miso = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
      model[i] = 32'd0;
    end
    for (int i = 0; i < 128; i++) slave_reg[i] = 8'($urandom);
    slave_reg[5] = 8'h3C;

    repeat (3) @(negedge clk);
    check("rst_buf_en", buf_en, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Directed entries plus a handful of random words with random flag combinations.
    load(8'h05, 32'h4000_85A5);
    load(8'h12, 32'h4000_1234);
    load(8'h20, 32'hC000_0011);
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      load(8'(8'h40 + i * 24), w);
    end
    build_expected();
    enable = 1'b1;
    drain("phase_a");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("entry05_result", mem[8'h05], 32'hC000_853C);
    check("entry12_result", mem[8'h12], 32'hC000_1234);
    check("entry20_untouched", mem[8'h20], 32'hC000_0011);

    for (int i = 0; i < 256; i++) load(8'(i), 32'd0);
    f0 = cs_falls;
    r0 = reads;
    enable = 1'b1;
    repeat (2000) @(negedge clk);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_scan_no_cs", cs_falls, f0);
    check("idle_scan_wrapped", (reads - r0) > 256, 1);

    load(8'd253, rand_pending(1'b0));
    build_expected();
    enable = 1'b1;
    drain("to_253");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("ptr_after_253", scan_ptr, 254);
    w = rand_pending(1'b1);
    load(8'd254, w);
    load(8'd1, rand_pending(1'b0));
    build_expected();
    enable = 1'b1;
    drain("wrap_254_1");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("entry254_result", mem[8'd254], wb_word(w));

    w30 = rand_pending(1'b1);
    load(8'h30, w30);
    load(8'h31, rand_pending(1'b0));
    build_expected();
    enable = 1'b1;
    t = 0;
    while (!(rise_cnt == 7 && !sclk && !cs_n) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("abort_point_reached", t < 6000, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    exp_dropped += exp_q.size();
    exp_q.delete();
    frame_q.delete();
    scan_ptr = 8'd0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("aborted_entry_untouched", mem[8'h30], w30);
    build_expected();
    enable = 1'b1;
    drain("after_abort");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("entry30_result", mem[8'h30], wb_word(w30));

    load(8'h40, rand_pending(1'b1));
    build_expected();
    enable = 1'b1;
    t = 0;
    while (cs_n && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("frame_started", t < 6000, 1);
    enable = 1'b0;
    drain("disable_mid_msg");
    repeat (10) @(negedge clk);
    r0 = reads;
    repeat (100) @(negedge clk);
    check("hold_idle_after_disable", reads, r0);

    check("busy_pulses", busy_rises, exp_total - exp_dropped + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
